// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller for a single-port async SRAM with WAIT_CYCLES fixed wait states.
// A request stalls the pipeline (ready=0) for WAIT_CYCLES+1 cycles; inputs are ignored until the next IDLE.
module mem_stage_sram_ctrl #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int SRAM_ADDR_WIDTH = 18,
  parameter int WAIT_CYCLES     = 5,
  parameter int BASE_ADDR       = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_en,
  input  logic                       wr_en,
  input  logic [ADDR_WIDTH-1:0]      address,
  input  logic [DATA_WIDTH-1:0]      write_data,
  output logic [DATA_WIDTH-1:0]      read_data,
  output logic                       ready,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0]      sram_dq_out,
  output logic                       sram_dq_oe,
  input  logic [DATA_WIDTH-1:0]      sram_dq_in,
  output logic                       sram_we_n,
  output logic                       sram_oe_n
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       is_wr_q, is_wr_d;
  logic [DATA_WIDTH-1:0]      read_data_q, read_data_d;
  logic [SRAM_ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_WIDTH-1:0]      dq_out_q, dq_out_d;
  logic                       dq_oe_q, dq_oe_d;
  logic                       we_n_q, we_n_d;
  logic                       oe_n_q, oe_n_d;
  logic                       req;
  logic                       access_next;

  assign req = rd_en | wr_en;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    read_data_d = read_data_q;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          // Write takes priority when both enables are raised.
          is_wr_d     = wr_en;
          sram_addr_d = SRAM_ADDR_WIDTH'((address - ADDR_WIDTH'(BASE_ADDR)) >> 2);
          dq_out_d    = write_data;
          cnt_d       = '0;
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          if (!is_wr_q) begin
            read_data_d = sram_dq_in;
          end
        end
      end
      S_DONE: begin
        // Requests still visible here belong to the completing instruction.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes are registered from the next state so they toggle with the state flop.
    access_next = (state_d == S_ACCESS);
    we_n_d      = ~(access_next & is_wr_d);
    dq_oe_d     = access_next & is_wr_d;
    oe_n_d      = ~(access_next & ~is_wr_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
    end
  end

  // Freeze must reach the hazard logic in the same cycle the request appears.
  assign ready = (state_q == S_IDLE) ? ~req : (state_q == S_DONE);

  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_n   = oe_n_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: random loads/stores against a word-addressed memory model.
module tb_mem_stage_sram_ctrl;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int SAW  = 18;
  localparam int W    = 5;
  localparam int BASE = 1024;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           rd_en;
  logic           wr_en;
  logic [AW-1:0]  address;
  logic [DW-1:0]  write_data;
  logic [DW-1:0]  read_data;
  logic           ready;
  logic [SAW-1:0] sram_addr;
  logic [DW-1:0]  sram_dq_out;
  logic           sram_dq_oe;
  logic [DW-1:0]  sram_dq_in;
  logic           sram_we_n;
  logic           sram_oe_n;

  always #5 clk = ~clk;

  mem_stage_sram_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SRAM_ADDR_WIDTH(SAW),
    .WAIT_CYCLES(W), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst_n), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] sram_mem [int];
  logic [31:0] ref_mem  [int];
  logic [31:0] exp_rd;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int idx);
    return (32'(idx) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic int word_idx(input logic [31:0] a);
    logic [31:0] d;
    d = (a - 32'(BASE)) >> 2;
    return int'({14'b0, d[17:0]});
  endfunction

  function automatic logic [31:0] ref_read(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
  endfunction

  // Async SRAM behaviour, evaluated once per cycle away from the clock edge.
  task automatic sram_tick();
    int a;
    a = int'({14'b0, sram_addr});
    if (!sram_we_n && sram_dq_oe) sram_mem[a] = sram_dq_out;
    if (!sram_oe_n) sram_dq_in = sram_mem.exists(a) ? sram_mem[a] : init_word(a);
    else            sram_dq_in = $urandom;
  endtask

  task automatic check_idle_pins(input string tag);
    check_eq({tag, "_we_n"}, 32'(sram_we_n), 32'd1);
    check_eq({tag, "_oe_n"}, 32'(sram_oe_n), 32'd1);
    check_eq({tag, "_dq_oe"}, 32'(sram_dq_oe), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rd_en = 1'b0; wr_en = 1'b0;
      @(negedge clk);
      check_eq("idle_ready", 32'(ready), 32'd1);
      check_idle_pins("idle");
      sram_tick();
    end
  endtask

  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit hold_done);
    int idx;
    bit is_wr;
    idx   = word_idx(addr);
    is_wr = wr;
    @(posedge clk); #1;
    rd_en = rd; wr_en = wr; address = addr; write_data = wdata;
    @(negedge clk);
    check_eq("req_ready", 32'(ready), 32'd0);
    sram_tick();
    for (int c = 1; c <= W; c++) begin
      @(posedge clk); #1;
      rd_en = 1'($urandom); wr_en = 1'($urandom);
      address = $urandom; write_data = $urandom;
      @(negedge clk);
      check_eq("acc_ready", 32'(ready), 32'd0);
      check_eq("acc_addr", 32'(sram_addr), 32'(idx));
      check_eq("acc_we_n", 32'(sram_we_n), 32'(!is_wr));
      check_eq("acc_oe_n", 32'(sram_oe_n), 32'(is_wr));
      check_eq("acc_dq_oe", 32'(sram_dq_oe), 32'(is_wr));
      if (is_wr) check_eq("acc_dq_out", sram_dq_out, wdata);
      sram_tick();
    end
    if (is_wr) ref_mem[idx] = wdata;
    else       exp_rd = ref_read(idx);
    @(posedge clk); #1;
    if (hold_done) begin
      rd_en = rd; wr_en = wr; address = addr; write_data = wdata;
    end else begin
      rd_en = 1'b0; wr_en = 1'b0;
    end
    @(negedge clk);
    check_eq("done_ready", 32'(ready), 32'd1);
    check_idle_pins("done");
    check_eq("done_rdata", read_data, exp_rd);
    sram_tick();
  endtask

  initial begin
    rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    address = '0; write_data = '0; sram_dq_in = '0;
    exp_rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_idle_pins("rst");
    check_eq("rst_rdata", read_data, 32'd0);
    check_eq("rst_addr", 32'(sram_addr), 32'd0);
    check_eq("rst_dq_out", sram_dq_out, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    idle(10);

    // Directed load / store / both-enables / alias cases.
    sram_mem[2] = 32'hCAFEBABE;
    ref_mem[2]  = 32'hCAFEBABE;
    do_access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
    check_eq("tp_load_val", read_data, 32'hCAFEBABE);
    do_access(1'b0, 1'b1, 32'd1024, 32'h12345678, 1'b0);
    check_eq("tp_store_keep", read_data, 32'hCAFEBABE);
    idle(1);
    do_access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b1);
    do_access(1'b1, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b1);
    idle(2);
    do_access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
    check_eq("both_wrote", read_data, 32'hDEADBEEF);
    do_access(1'b0, 1'b1, 32'h0000_0000, 32'hA5A5_0F0F, 1'b0);
    do_access(1'b1, 1'b0, 32'h0100_0000, 32'h0, 1'b0);
    check_eq("wrap_alias", read_data, 32'hA5A5_0F0F);

    // Reset in the middle of a load.
    @(posedge clk); #1;
    rd_en = 1'b1; wr_en = 1'b0; address = 32'd1064;
    @(negedge clk); sram_tick();
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (c < 3) sram_tick();
    end
    check_eq("pre_rst_oe_n", 32'(sram_oe_n), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_pins("mid_rst");
    check_eq("mid_rst_rdata", read_data, 32'd0);
    rd_en = 1'b0;
    #1;
    check_eq("mid_rst_ready", 32'(ready), 32'd1);
    exp_rd = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      logic        r;
      logic        w;
      int          op;
      op = $urandom_range(0, 2);
      r  = (op != 1);
      w  = (op != 0);
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = 32'(BASE) + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
      do_access(r, w, a, $urandom, 1'($urandom));
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
Sequences data-memory accesses issued by the MEM stage to an external single-port asynchronous SRAM with fixed wait states.
- Sits between the EXE/MEM pipeline register outputs (mem read/write enables, ALU result as address, store data) and the SRAM pins.
- Drives `ready`; the hazard/freeze logic holds all pipeline registers while `ready` is low.
- Returns load data to the MEM/WB register's memory-result input.

Parameters:
DATA_WIDTH, 32, width of CPU data and SRAM data bus
ADDR_WIDTH, 32, width of CPU byte address
SRAM_ADDR_WIDTH, 18, width of SRAM word address
WAIT_CYCLES, 5, SRAM access cycles per transaction (legal range 1..15)
BASE_ADDR, 1024, CPU byte address mapped to SRAM word 0

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
rd_en  in  1  load request from MEM stage
wr_en  in  1  store request from MEM stage
address  in  ADDR_WIDTH  CPU byte address (ALU result)
write_data  in  DATA_WIDTH  store data
read_data  out  DATA_WIDTH  load result, registered
ready  out  1  1 = no access pending or access completing; 0 = freeze pipeline
sram_addr  out  SRAM_ADDR_WIDTH  SRAM word address, registered
sram_dq_out  out  DATA_WIDTH  SRAM write data, registered
sram_dq_oe  out  1  1 = drive sram_dq_out onto DQ bus
sram_dq_in  in  DATA_WIDTH  SRAM read data
sram_we_n  out  1  SRAM write strobe, active-low
sram_oe_n  out  1  SRAM output enable, active-low

Behaviour:
Reset (rst=0):
- Asynchronously forces IDLE and clears the counter.
- read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, sram_oe_n=1.
- ready follows the combinational rule below.

FSM states: IDLE, ACCESS, DONE.

IDLE:
- req = rd_en | wr_en.
- ready = ~req, combinational, so the freeze takes effect in the request cycle.
- On req:
  - latch op (write wins if both enables are high; rd_en is then ignored).
  - latch sram_addr = ((address - BASE_ADDR) >> 2) truncated to SRAM_ADDR_WIDTH; modulo wrap, no error for out-of-range addresses.
  - latch sram_dq_out = write_data.
  - clear counter; go to ACCESS.

ACCESS:
- ready=0.
- Write: sram_we_n=0 and sram_dq_oe=1 for all cycles.
- Read: sram_oe_n=0 for all cycles.
- Counter increments each cycle.
- On the cycle where counter = WAIT_CYCLES-1:
  - read: read_data <= sram_dq_in.
  - go to DONE.
- Counter is $clog2(WAIT_CYCLES+1) bits and never wraps.

DONE:
- ready=1 for exactly one cycle; strobes deasserted (we_n=1, oe_n=1, dq_oe=0).
- read_data valid (writes leave read_data unchanged).
- Unconditionally go to IDLE; any request visible this cycle belongs to the completing instruction and is NOT restarted.

Latency: request in cycle 0 -> ACCESS cycles 1..WAIT_CYCLES -> DONE (ready=1) in cycle WAIT_CYCLES+1. Total stall = WAIT_CYCLES+1 cycles.

Other rules:
- Back-to-back requests: the next request is sampled in the IDLE cycle after DONE; there is one IDLE cycle per transaction.
- Request inputs changing or dropping in ACCESS/DONE are ignored; the latched op, address and data are used.
- read_data holds its value between loads.
- Strobes are registered (glitch-free) and derived from the state register.
- Reset mid-ACCESS aborts the transaction, with strobes deasserted immediately.
- No outputs are undefined after reset.

Test Plan:
1. Idle: rd_en=wr_en=0 for 10 cycles -> ready=1 throughout; strobes inactive; sram_dq_oe=0.
2. Load, WAIT_CYCLES=5, address=1032, sram_dq_in=0xCAFEBABE:
   - ready=0 in cycles 0..5.
   - sram_addr=2; sram_oe_n=0 in cycles 1..5.
   - ready=1 and read_data=0xCAFEBABE in cycle 6.
3. Store, address=1024, write_data=0x12345678:
   - sram_addr=0, sram_dq_out=0x12345678.
   - sram_we_n=0 and sram_dq_oe=1 in cycles 1..5; ready=1 in cycle 6.
   - read_data unchanged.
4. Back-to-back load then store:
   - second access begins its ACCESS phase exactly 2 cycles after the first DONE.
   - no spurious restart during DONE.
   - both=1 with address=1028 -> write performed, sram_oe_n stays 1.
5. Reset pulse in cycle 3 of an ACCESS:
   - strobes go inactive asynchronously; state IDLE.
   - read_data=0; ready=1 if no request is present after release.
